// File: rtl/neuron_register_bank.sv
// Bus register bank and start/done controller for the perceptron core.
// Define NEURON_REGBANK_READBACK_EN to make coefficient, offset and input registers readable.
module neuron_register_bank #(
    parameter int unsigned             NUM_COEFF = 20,
    parameter int unsigned             DATA_W    = 32,
    parameter int unsigned             ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = 12'h800
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [ADDR_W-1:0]           Address,
    input  logic [DATA_W-1:0]           WriteData,
    input  logic                        Write,
    input  logic                        Read,
    output logic [DATA_W-1:0]           ReadData,
    output logic                        Ack,
    output logic                        Error,
    output logic [NUM_COEFF*DATA_W-1:0] Coeff,
    output logic [DATA_W-1:0]           Offset,
    output logic [DATA_W-1:0]           InputData,
    output logic                        Start,
    input  logic                        CoreDone,
    input  logic [DATA_W-1:0]           CoreResult,
    output logic                        Busy,
    output logic                        DoneFlag
);
    localparam int unsigned IW = ADDR_W - 2;
    localparam logic [IW-1:0] IDX_OFF = IW'(NUM_COEFF);
    localparam logic [IW-1:0] IDX_CTL = IW'(NUM_COEFF + 1);
    localparam logic [IW-1:0] IDX_IN  = IW'(NUM_COEFF + 2);
    localparam logic [IW-1:0] IDX_RES = IW'(NUM_COEFF + 3);

    logic [NUM_COEFF-1:0][DATA_W-1:0] coeff_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rd_val;
    logic [ADDR_W-1:0] rel;
    logic [IW-1:0]     widx;
    logic mapped, is_coeff, is_off, is_ctl, is_in, is_res;
    logic wr_ok, start_fire, done_v;

    // Word index relative to coefficient 0; everything above the result word is unmapped.
    assign rel      = Address - BASE_ADDR;
    assign widx     = rel[ADDR_W-1:2];
    assign mapped   = (Address[1:0] == 2'b00) && (Address >= BASE_ADDR) && (widx <= IDX_RES);
    assign is_coeff = mapped && (widx < IDX_OFF);
    assign is_off   = mapped && (widx == IDX_OFF);
    assign is_ctl   = mapped && (widx == IDX_CTL);
    assign is_in    = mapped && (widx == IDX_IN);
    assign is_res   = mapped && (widx == IDX_RES);

    // Busy is the pre-edge value, so a CoreDone in the same cycle does not unlock the write.
    assign wr_ok      = Write && (is_ctl || ((is_coeff || is_off || is_in) && !Busy));
    assign start_fire = wr_ok && is_in;
    assign done_v     = CoreDone && Busy;
    assign Coeff      = coeff_q;

    always_comb begin
        rd_val = '0;
        if (is_ctl)
            rd_val = {{(DATA_W-2){1'b0}}, Busy, DoneFlag};
        else if (is_res)
            rd_val = result_q;
`ifdef NEURON_REGBANK_READBACK_EN
        else if (is_off)
            rd_val = Offset;
        else if (is_in)
            rd_val = InputData;
        else if (is_coeff) begin
            for (int i = 0; i < NUM_COEFF; i++)
                if (widx == IW'(i)) rd_val = coeff_q[i];
        end
`endif
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COEFF; g++) begin : g_coeff
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n)
                    coeff_q[g] <= '0;
                else if (wr_ok && is_coeff && (widx == IW'(g)))
                    coeff_q[g] <= WriteData;
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ReadData  <= '0;
            Ack       <= 1'b0;
            Error     <= 1'b0;
            Start     <= 1'b0;
            Offset    <= '0;
            InputData <= '0;
            result_q  <= '0;
            Busy      <= 1'b0;
            DoneFlag  <= 1'b0;
        end else begin
            Ack      <= Write || Read;
            Error    <= Write ? !wr_ok : (Read && !mapped);
            ReadData <= (Read && !Write && mapped) ? rd_val : '0;
            Start    <= start_fire;
            if (wr_ok && is_off) Offset <= WriteData;
            if (wr_ok && is_in)  InputData <= WriteData;
            if (done_v)          result_q <= CoreResult;
            if (start_fire)      Busy <= 1'b1;
            else if (done_v)     Busy <= 1'b0;
            // A completion in the same cycle as a status clear leaves the flag set.
            if (done_v)
                DoneFlag <= 1'b1;
            else if (start_fire || (wr_ok && is_ctl && WriteData[0]))
                DoneFlag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_neuron_register_bank.sv
// Scoreboard bench: bus accesses queue their expected response, a negedge monitor checks each Ack.
module tb_neuron_register_bank;
    localparam int NC = 20;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic          Write, Read;
    logic [DW-1:0] ReadData;
    logic          Ack, Error;
    logic [NC*DW-1:0] Coeff;
    logic [DW-1:0] Offset, InputData;
    logic          Start;
    logic          CoreDone;
    logic [DW-1:0] CoreResult;
    logic          Busy, DoneFlag;

    neuron_register_bank #(.NUM_COEFF(NC), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(12'h800)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .WriteData(WriteData),
        .Write(Write), .Read(Read), .ReadData(ReadData), .Ack(Ack), .Error(Error),
        .Coeff(Coeff), .Offset(Offset), .InputData(InputData), .Start(Start),
        .CoreDone(CoreDone), .CoreResult(CoreResult), .Busy(Busy), .DoneFlag(DoneFlag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

`ifdef NEURON_REGBANK_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle bus strobe; returns one cycle later, when Ack and register updates are visible.
    task automatic bus(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] erd, input logic eerr);
        exp_t e;
        e.rd = erd; e.err = eerr; e.addr = a;
        Write = w; Read = r; Address = a; WriteData = d;
        sb.push_back(e);
        @(posedge Clk); #1;
        Write = 1'b0; Read = 1'b0;
    endtask

    task automatic done_pulse(input logic [DW-1:0] res);
        CoreDone = 1'b1; CoreResult = res;
        @(posedge Clk); #1;
        CoreDone = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (Reset_n && Ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'b0, Ack}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rdata@%0h", e.addr), ReadData, e.rd);
                check($sformatf("error@%0h", e.addr), {31'b0, Error}, {31'b0, e.err});
            end
        end
    end

    function automatic logic [DW-1:0] cf(input int i);
        return Coeff[i*DW +: DW];
    endfunction

    initial begin
        Reset_n = 1'b0; Address = '0; WriteData = '0; Write = 1'b0; Read = 1'b0;
        CoreDone = 1'b0; CoreResult = '0;
        #12;
        check("rst_ack", {31'b0, Ack}, 0);
        check("rst_busy", {31'b0, Busy}, 0);
        check("rst_done", {31'b0, DoneFlag}, 0);
        check("rst_rdata", ReadData, 0);
        check("rst_coeff3", cf(3), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Coefficient write and readback
        bus(1, 0, 12'h80C, 32'hA5, 0, 0);
        check("coeff3_wr", cf(3), 32'hA5);
        check("no_start_coeff", {31'b0, Start}, 0);
        bus(0, 1, 12'h80C, 0, RB ? 32'hA5 : 32'h0, 0);
        bus(1, 0, 12'h84C, 32'h1357, 0, 0);
        check("coeff19_wr", cf(19), 32'h1357);

        // Input write starts the core; configuration locked while busy
        bus(1, 0, 12'h858, 32'h10, 0, 0);
        check("start_hi", {31'b0, Start}, 1);
        check("busy_hi", {31'b0, Busy}, 1);
        check("input_wr", InputData, 32'h10);
        @(posedge Clk); #1;
        check("start_one_cycle", {31'b0, Start}, 0);
        check("busy_held", {31'b0, Busy}, 1);
        bus(1, 0, 12'h800, 32'h5, 0, 1);
        check("coeff0_locked", cf(0), 0);
        bus(1, 0, 12'h850, 32'h7, 0, 1);
        check("offset_locked", Offset, 0);
        bus(0, 1, 12'h854, 0, 32'h2, 0);

        // Completion
        done_pulse(32'h1234);
        check("busy_cleared", {31'b0, Busy}, 0);
        check("done_set", {31'b0, DoneFlag}, 1);
        bus(0, 1, 12'h85C, 0, 32'h1234, 0);
        bus(0, 1, 12'h854, 0, 32'h1, 0);
        bus(1, 0, 12'h854, 32'h1, 0, 0);
        check("done_cleared", {31'b0, DoneFlag}, 0);
        bus(0, 1, 12'h854, 0, 32'h0, 0);

        // Unmapped and rejected accesses, back-to-back
        bus(1, 0, 12'h801, 32'hFF, 0, 1);
        bus(0, 1, 12'h900, 0, 0, 1);
        bus(0, 1, 12'h860, 0, 0, 1);
        bus(0, 1, 12'h7FC, 0, 0, 1);
        bus(1, 0, 12'h85C, 32'hFFFF, 0, 1);
        check("coeff0_unchanged", cf(0), 0);
        check("coeff3_unchanged", cf(3), 32'hA5);
        bus(0, 1, 12'h85C, 0, 32'h1234, 0);

        // Simultaneous write and read: write wins, single ack
        bus(1, 1, 12'h804, 32'h55, 0, 0);
        check("wr_rd_coeff1", cf(1), 32'h55);
        bus(1, 0, 12'h850, 32'h99, 0, 0);
        check("offset_wr", Offset, 32'h99);
        bus(0, 1, 12'h850, 0, RB ? 32'h99 : 32'h0, 0);
        bus(0, 1, 12'h858, 0, RB ? 32'h10 : 32'h0, 0);

        // Input write rejected when CoreDone lands the same cycle
        bus(1, 0, 12'h858, 32'h20, 0, 0);
        check("start2", {31'b0, Start}, 1);
        CoreDone = 1'b1; CoreResult = 32'hBEEF;
        bus(1, 0, 12'h858, 32'h30, 0, 1);
        CoreDone = 1'b0;
        check("race_no_start", {31'b0, Start}, 0);
        check("race_busy0", {31'b0, Busy}, 0);
        check("race_done1", {31'b0, DoneFlag}, 1);
        check("race_input_kept", InputData, 32'h20);
        bus(1, 0, 12'h858, 32'h30, 0, 0);
        check("retry_start", {31'b0, Start}, 1);
        check("retry_done_clr", {31'b0, DoneFlag}, 0);

        // Done set beats status clear
        CoreDone = 1'b1; CoreResult = 32'h77;
        bus(1, 0, 12'h854, 32'h1, 0, 0);
        CoreDone = 1'b0;
        check("set_wins", {31'b0, DoneFlag}, 1);
        check("busy_after_done", {31'b0, Busy}, 0);
        done_pulse(32'hDEAD);
        bus(0, 1, 12'h85C, 0, 32'h77, 0);

        // Asynchronous reset while busy and while Start is high
        bus(1, 0, 12'h858, 32'h40, 0, 0);
        sb.delete();
        #1 Reset_n = 1'b0;
        #1;
        check("arst_start", {31'b0, Start}, 0);
        check("arst_busy", {31'b0, Busy}, 0);
        check("arst_ack", {31'b0, Ack}, 0);
        check("arst_input", InputData, 0);
        check("arst_offset", Offset, 0);
        check("arst_coeff3", cf(3), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        bus(0, 1, 12'h854, 0, 32'h0, 0);
        bus(0, 1, 12'h85C, 0, 32'h0, 0);

        repeat (3) @(posedge Clk);
        #1 check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/neuron_register_bank.md
# neuron_register_bank

Parametrised, clocked register bank and start controller for the perceptron core. Decodes bus writes/reads into NUM_COEFF training coefficients, an offset, an input register, a control/status word and a captured result. Issues a one-cycle start pulse to the neuron core, tracks busy/done, and refuses configuration writes while the core runs. Sits between the processor bus interface and the neuron datapath.

## Interface
- NUM_COEFF, 20, number of training-coefficient registers (1..64)
- DATA_W, 32, register and bus data width
- ADDR_W, 12, bus address width
- BASE_ADDR, 12'h800, byte address of coefficient 0
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Address  in  ADDR_W  byte address, sampled when Write or Read is high
- WriteData  in  DATA_W  write data
- Write  in  1  write strobe, one cycle per access
- Read  in  1  read strobe, one cycle per access
- ReadData  out  DATA_W  registered read data, valid with Ack
- Ack  out  1  one-cycle access acknowledge
- Error  out  1  valid with Ack; access rejected or unmapped
- Coeff  out  NUM_COEFF*DATA_W  coefficient i at [i*DATA_W +: DATA_W]
- Offset  out  DATA_W  offset coefficient
- InputData  out  DATA_W  neuron input value
- Start  out  1  one-cycle start pulse to the core
- CoreDone  in  1  one-cycle completion pulse from the core
- CoreResult  in  DATA_W  core result, valid with CoreDone
- Busy  out  1  core running
- DoneFlag  out  1  sticky completion flag

## Operation
- Address map, with E = BASE_ADDR + 4*NUM_COEFF: coefficient i at BASE_ADDR + 4*i; offset at E; control/status at E+4; input at E+8; result at E+12 (read-only). For the defaults: 0x800..0x84C, 0x850, 0x854, 0x858, 0x85C.
- Unmapped access: any address outside the map, or with Address[1:0] != 0. The block returns Ack with Error=1, makes no state change, and returns ReadData=0.
- Write to a coefficient, offset or input while Busy=0 updates that register.
- Write to a coefficient, offset or input while Busy=1 is rejected: Ack with Error=1, register unchanged.
- Write to the input while Busy=0 also fires Start. Busy sets and DoneFlag clears.
- Write to control/status: bit0=1 clears DoneFlag; other bits are ignored. This write is never rejected.
- Write to the result address is rejected (Error=1).
- Read of control/status returns {.., Busy, DoneFlag} in bits [1:0], with upper bits 0.
- CoreDone with Busy=1: CoreResult is captured into the result register, Busy clears, DoneFlag sets. CoreDone with Busy=0 is ignored.
- Write and Read asserted together: the block performs the write, ignores the read and issues a single Ack.
- CoreDone and a rejected input write in the same cycle: the write is still rejected, because Busy is sampled before the update. Busy clears on that edge.
- CoreDone and a status write with bit0=1 in the same cycle: DoneFlag ends at 1 (set wins).

## Timing
- All state updates on the rising edge of Clk. Reset_n low asynchronously clears every register and output to 0: Coeff, Offset, InputData, result, ReadData, Ack, Error, Start, Busy, DoneFlag.
- Register write: the value is visible on Coeff/Offset/InputData the cycle after the strobe edge.
- Ack/Error/ReadData: exactly one cycle after the strobe edge, held high for one cycle.
- Start: high for exactly one cycle, coincident with Ack of the input write. Busy rises on the same edge.
- CoreDone to Busy=0, DoneFlag=1 and the result readable: 1 cycle.
- Back-to-back strobes on consecutive cycles are each acknowledged; no wait states.
- Reset mid-operation: Busy is dropped and Start is suppressed. The core must be reset by the same Reset_n.

## Configuration
- NEURON_REGBANK_READBACK_EN defined: full read path; all mapped registers are readable.
- Not defined: reads still receive Ack, with Error=0 for mapped and Error=1 for unmapped addresses. ReadData is forced to 0 except for control/status and result, which remain readable. This removes the wide coefficient read mux.

## Test plan
- Reset, then write 0x0000_00A5 to 0x80C and read 0x80C -> Coeff[3]=0xA5 one cycle after the write, Ack with Error=0, ReadData=0xA5 (macro on).
- Write 0x10 to 0x858 -> Start high for one cycle, Busy=1. Then write 0x5 to 0x800 -> Ack with Error=1, Coeff[0] unchanged.
- While Busy, pulse CoreDone with CoreResult=0x1234 -> next cycle Busy=0 and DoneFlag=1. Read 0x85C -> 0x1234. Read 0x854 -> 0x1.
- Write 0x801 and read 0x900 -> Ack with Error=1 for both, ReadData=0, no register changes.
- Write to 0x858 while CoreDone pulses in the same cycle -> Error=1, no Start, Busy=0 afterwards. Repeat write -> Start fires.
- Assert Reset_n low mid-busy between clock edges -> all outputs 0 immediately. After release, a read of 0x854 returns 0.
